// File: rtl/alu_arbiter_if.sv
// Bundle of the two request ports, the ALU operand/result bus and the response port.
// "slave" is the arbiter side; "master" is the requesters, ALU and consumer side.
interface alu_arbiter_if;
    logic       req0_valid;
    logic [2:0] req0_opcode;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req0_ready;

    logic       req1_valid;
    logic [2:0] req1_opcode;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       req1_ready;

    logic [2:0] alu_opcode;
    logic [3:0] alu_src_a;
    logic [3:0] alu_src_b;
    logic [5:0] alu_out;
    logic       alu_overflow;
    logic       alu_zero;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [5:0] rsp_data;
    logic       rsp_overflow;
    logic       rsp_zero;

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_a, req1_b,
        output req1_ready,
        output alu_opcode, alu_src_a, alu_src_b,
        input  alu_out, alu_overflow, alu_zero,
        output rsp_valid, rsp_id, rsp_data, rsp_overflow, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_a, req1_b,
        input  req1_ready,
        input  alu_opcode, alu_src_a, alu_src_b,
        output alu_out, alu_overflow, alu_zero,
        input  rsp_valid, rsp_id, rsp_data, rsp_overflow, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN for strict priority to requester 0.
module alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    alu_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] op_cnt,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic             win_q, win_d;
    logic [2:0]       alu_opcode_q, alu_opcode_d;
    logic [3:0]       alu_src_a_q, alu_src_a_d;
    logic [3:0]       alu_src_b_q, alu_src_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [5:0]       rsp_data_q, rsp_data_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic             grant0, grant1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; requesters hold valid/payload until ready, the response holds
    // until rsp_ready. reqN_ready is the only combinational output.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
        grant1 = bus.req1_valid && (!bus.req0_valid || prio_q);
    end

    always_comb begin
        state_d        = state_q;
        prio_d         = prio_q;
        win_d          = win_q;
        alu_opcode_d   = alu_opcode_q;
        alu_src_a_d    = alu_src_a_q;
        alu_src_b_d    = alu_src_b_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_data_d     = rsp_data_q;
        rsp_ovf_d      = rsp_ovf_q;
        rsp_zero_d     = rsp_zero_q;
        op_cnt_d       = op_cnt_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req0_ready = grant0 && !reset;
                bus.req1_ready = grant1 && !reset;
                if (grant0 || grant1) begin
                    alu_opcode_d = grant1 ? bus.req1_opcode : bus.req0_opcode;
                    alu_src_a_d  = grant1 ? bus.req1_a      : bus.req0_a;
                    alu_src_b_d  = grant1 ? bus.req1_b      : bus.req0_b;
                    win_d        = grant1;
`ifdef ALU_ARB_FIXED_PRIO_EN
                    prio_d       = 1'b0;
`else
                    prio_d       = ~grant1;
`endif
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = bus.alu_out;
                rsp_ovf_d   = bus.alu_overflow;
                rsp_zero_d  = bus.alu_zero;
                rsp_id_d    = win_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_cnt_d    = op_cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            win_q        <= 1'b0;
            alu_opcode_q <= '0;
            alu_src_a_q  <= '0;
            alu_src_b_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
            op_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            win_q        <= win_d;
            alu_opcode_q <= alu_opcode_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_zero_q   <= rsp_zero_d;
            op_cnt_q     <= op_cnt_d;
        end
    end

    assign bus.alu_opcode   = alu_opcode_q;
    assign bus.alu_src_a    = alu_src_a_q;
    assign bus.alu_src_b    = alu_src_b_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign op_cnt           = op_cnt_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table of single operations, hand-written
// contention, back-pressure, flag, reset-abort and counter-wrap sequences.
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] op_cnt;
    logic [1:0] dbg_state;
    logic [1:0] op_cnt2;
    logic [1:0] dbg_state2;
    logic       ovr;
    int         tests = 0;
    int         fails = 0;
    int         exp_cnt = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    alu_arbiter_if bus ();
    alu_arbiter_if bus2 ();

    alu_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .op_cnt(op_cnt), .dbg_state_o(dbg_state)
    );

    alu_arbiter #(.CNT_W(2)) dut_wrap (
        .clk(clk), .reset(reset), .bus(bus2), .op_cnt(op_cnt2), .dbg_state_o(dbg_state2)
    );

    // Stand-in ALU: {overflow, zero, out}; override forces 0 with both flags set.
    function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b, input logic force_flags);
        logic [5:0] s;
        s = {2'b00, a} + {2'b00, b} + {3'b000, op};
        if (force_flags) return {1'b1, 1'b1, 6'd0};
        return {(s > 6'd15), (s == 6'd0), s};
    endfunction

    always_comb {bus.alu_overflow, bus.alu_zero, bus.alu_out} =
        alu_model(bus.alu_opcode, bus.alu_src_a, bus.alu_src_b, ovr);
    always_comb {bus2.alu_overflow, bus2.alu_zero, bus2.alu_out} =
        alu_model(bus2.alu_opcode, bus2.alu_src_a, bus2.alu_src_b, 1'b0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected response pushed on request handshake, popped on response handshake.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.req0_ready === 1'b1)
                exp_q.push_back({1'b0, alu_model(bus.req0_opcode, bus.req0_a, bus.req0_b, ovr)});
            if (bus.req1_ready === 1'b1)
                exp_q.push_back({1'b1, alu_model(bus.req1_opcode, bus.req1_a, bus.req1_b, ovr)});
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got id=%0d data=0x%0h with empty queue",
                             bus.rsp_id, bus.rsp_data);
                end else begin
                    check("rsp_word", {bus.rsp_id, bus.rsp_overflow, bus.rsp_zero, bus.rsp_data},
                          exp_q.pop_front());
                end
            end
        end
    end

    typedef struct {
        logic       v0;
        logic [2:0] op0;
        logic [3:0] a0;
        logic [3:0] b0;
        logic       v1;
        logic [2:0] op1;
        logic [3:0] a1;
        logic [3:0] b1;
        logic       exp_id;
    } vec_t;

    vec_t vecs[6];

    task automatic set_req(input vec_t v);
        bus.req0_valid = v.v0; bus.req0_opcode = v.op0; bus.req0_a = v.a0; bus.req0_b = v.b0;
        bus.req1_valid = v.v1; bus.req1_opcode = v.op1; bus.req1_a = v.a1; bus.req1_b = v.b1;
    endtask

    task automatic drop_req();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_grant_seen"}, got, 1'b1);
    endtask

    task automatic wait_rsp(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_rsp_seen"}, got, 1'b1);
    endtask

    // One full operation with rsp_ready high, checked at T, T+1, T+2 and T+3.
    task automatic do_op(input vec_t v, input string name);
        logic [2:0] wop;
        logic [3:0] wa, wb;
        logic [7:0] res;
        wop = v.exp_id ? v.op1 : v.op0;
        wa  = v.exp_id ? v.a1  : v.a0;
        wb  = v.exp_id ? v.b1  : v.b0;
        @(posedge clk); #1;
        set_req(v);
        bus.rsp_ready = 1'b1;
        wait_grant(name);
        check({name, "_ready_pair"}, {bus.req0_ready, bus.req1_ready}, v.exp_id ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        drop_req();
        @(negedge clk);
        check({name, "_alu_regs"}, {bus.alu_opcode, bus.alu_src_a, bus.alu_src_b}, {wop, wa, wb});
        check({name, "_state_exec"}, dbg_state, S_EXEC);
        @(negedge clk);
        res = alu_model(wop, wa, wb, ovr);
        check({name, "_rsp"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_overflow, bus.rsp_zero, bus.rsp_data},
              {1'b1, v.exp_id, res});
        @(negedge clk);
        exp_cnt++;
        check({name, "_op_cnt"}, op_cnt, exp_cnt[7:0]);
        check({name, "_state_idle"}, dbg_state, S_IDLE);
    endtask

    logic       grants[$];
    logic       exp_g[4];
    logic [1:0] wrap_exp[5];
    vec_t       single;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ovr   = 1'b0;
        bus.rsp_ready = 1'b1;
        single = '{1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0};
        set_req(single);
        bus2.req0_valid = 1'b0; bus2.req0_opcode = 3'd0; bus2.req0_a = 4'd1; bus2.req0_b = 4'd1;
        bus2.req1_valid = 1'b0; bus2.req1_opcode = 3'd0; bus2.req1_a = 4'd0; bus2.req1_b = 4'd0;
        bus2.rsp_ready  = 1'b1;

        vecs[0] = '{1'b1, 3'd1, 4'd15, 4'd15, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0};
        vecs[1] = '{1'b0, 3'd0, 4'd0,  4'd0,  1'b1, 3'd2, 4'd4, 4'd9, 1'b1};
        vecs[2] = '{1'b1, 3'd0, 4'd1,  4'd2,  1'b1, 3'd3, 4'd6, 4'd6, 1'b0};
        vecs[3] = '{1'b1, 3'd4, 4'd9,  4'd9,  1'b1, 3'd5, 4'd2, 4'd3, FIXED ? 1'b0 : 1'b1};
        vecs[4] = '{1'b0, 3'd0, 4'd0,  4'd0,  1'b1, 3'd0, 4'd0, 4'd0, 1'b1};
        vecs[5] = '{1'b1, 3'd7, 4'd8,  4'd1,  1'b1, 3'd6, 4'd1, 4'd1, 1'b0};
        exp_g    = '{1'b0, FIXED ? 1'b0 : 1'b1, 1'b0, FIXED ? 1'b0 : 1'b1};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset state, with both requesters valid to show ready is held low.
        repeat (2) @(posedge clk);
        #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        check("reset_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        check("reset_alu", {bus.alu_opcode, bus.alu_src_a, bus.alu_src_b}, 11'd0);
        check("reset_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_overflow, bus.rsp_zero, bus.rsp_data}, 10'd0);
        check("reset_cnt", op_cnt, 8'd0);
        check("reset_state", dbg_state, S_IDLE);
        @(posedge clk); #1;
        reset = 1'b0;
        drop_req();

        single = '{1'b1, 3'd0, 4'd3, 4'd5, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0};
        do_op(single, "single");

        for (int i = 0; i < 6; i++) do_op(vecs[i], $sformatf("vec%0d", i));

        // Contention: both valid continuously from reset.
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 0;
        single = '{1'b1, 3'd0, 4'd1, 4'd1, 1'b1, 3'd2, 4'd3, 4'd4, 1'b0};
        set_req(single);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 40 && grants.size() < 4; k++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) grants.push_back(bus.req1_ready);
        end
        @(posedge clk); #1;
        drop_req();
        repeat (3) @(negedge clk);
        check("cont_grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            check($sformatf("cont_grant%0d", i), grants[i], exp_g[i]);
        exp_cnt = 4;
        check("cont_op_cnt", op_cnt, 8'd4);

        // Back-pressure: response held while req1 waits.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        single = '{1'b1, 3'd0, 4'd7, 4'd2, 1'b0, 3'd1, 4'd5, 4'd5, 1'b0};
        set_req(single);
        wait_grant("bp");
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        wait_rsp("bp");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, {1'b1, 1'b0, 6'd9});
            check("bp_ready_low", {bus.req0_ready, bus.req1_ready}, 2'b00);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_state", dbg_state, S_RESP);
        @(negedge clk);
        check("bp_after_state", dbg_state, S_IDLE);
        check("bp_next_grant", {bus.req0_ready, bus.req1_ready}, 2'b01);
        @(posedge clk); #1;
        drop_req();
        repeat (3) @(negedge clk);
        exp_cnt += 2;
        check("bp_op_cnt", op_cnt, exp_cnt[7:0]);

        // Flag capture.
        @(posedge clk); #1;
        ovr = 1'b1;
        single = '{1'b1, 3'd0, 4'd4, 4'd4, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0};
        do_op(single, "flags");
        @(posedge clk); #1;
        ovr = 1'b0;

        // Reset while holding a response; reset also beats a simultaneous accept.
        bus.rsp_ready = 1'b0;
        single = '{1'b1, 3'd3, 4'd1, 4'd1, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0};
        set_req(single);
        wait_grant("abort");
        @(posedge clk); #1;
        drop_req();
        wait_rsp("abort");
        @(posedge clk); #1;
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        single = '{1'b1, 3'd1, 4'd2, 4'd2, 1'b1, 3'd2, 4'd3, 4'd3, 1'b0};
        set_req(single);
        @(negedge clk);
        check("abort_ready_in_reset", {bus.req0_ready, bus.req1_ready}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_rsp_valid", bus.rsp_valid, 1'b0);
        check("abort_op_cnt", op_cnt, 8'd0);
        check("abort_alu", {bus.alu_opcode, bus.alu_src_a, bus.alu_src_b}, 11'd0);
        check("abort_state", dbg_state, S_IDLE);
        check("abort_next_grant", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(posedge clk); #1;
        drop_req();
        repeat (3) @(negedge clk);
        check("abort_after_cnt", op_cnt, 8'd1);

        // Counter wrap on the CNT_W=2 instance.
        @(posedge clk); #1;
        bus2.req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus2.rsp_valid && bus2.rsp_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            check($sformatf("wrap_rsp%0d_seen", i), got, 1'b1);
            @(negedge clk);
            check($sformatf("wrap_cnt%0d", i), op_cnt2, wrap_exp[i]);
        end
        @(posedge clk); #1;
        bus2.req0_valid = 1'b0;
        repeat (4) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between two requesters. Each request is a triple of 3-bit opcode and two 4-bit operands. The block arbitrates round-robin, registers the winning operands onto the ALU inputs, captures the result one cycle later, and returns it with the winner's ID through a valid/ready response port. It sits between the requester front-ends and the `alu` datapath; the `alu` itself is not modified.

## Interface
Parameters:
- `CNT_W`, default 8: width of the completed-operation counter.

Ports:
- `clk` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_opcode` in 3, `req0_a` in 4, `req0_b` in 4: requester 0 payload.
- `req0_ready` out 1: requester 0 request accepted this cycle.
- `req1_valid` in 1: requester 1 has an operation pending.
- `req1_opcode` in 3, `req1_a` in 4, `req1_b` in 4: requester 1 payload.
- `req1_ready` out 1: requester 1 request accepted this cycle.
- `alu_opcode` out 3, `alu_src_a` out 4, `alu_src_b` out 4: registered drive to the ALU `opcode`/`src_a`/`src_b`.
- `alu_out` in 6, `alu_overflow` in 1, `alu_zero` in 1: ALU results.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: requester that issued the response.
- `rsp_data` out 6: response result.
- `rsp_overflow` out 1, `rsp_zero` out 1: response flags.
- `op_cnt` out CNT_W: number of completed responses.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Reset (synchronous) sets:
  - state IDLE and `prio`=0;
  - `alu_opcode`/`alu_src_a`/`alu_src_b` = 0;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_overflow`=0, `rsp_zero`=0;
  - `op_cnt`=0.
- `reqN_ready` is combinational: high only in IDLE, only for the granted N, and only while `reqN_valid` is high. `reqN_ready` is 0 during reset.
- Grant in IDLE:
  - only one valid: that requester is granted;
  - both valid: requester `prio` is granted.
- IDLE with a grant: on the edge, latch the winner's payload into the `alu_*` registers, store the winner ID, set `prio` to the other requester, and go to EXEC. With no valid request, stay in IDLE.
- EXEC: the ALU settles on the registered operands. On the edge, capture `alu_out`/`alu_overflow`/`alu_zero` into `rsp_*`, set `rsp_valid`=1, and go to RESP.
- RESP: hold `rsp_*` stable until `rsp_valid && rsp_ready`. On that edge, clear `rsp_valid`, increment `op_cnt` (wrapping 2^CNT_W-1 → 0), and go to IDLE.
- The `alu_*` registers hold their last value outside the IDLE→EXEC load; they are not zeroed between operations.
- Requesters hold `valid` and payload stable until `ready`. A request whose `valid` drops before grant is never issued, and no error is raised.
- Reset mid-operation (EXEC or RESP) aborts the operation: the in-flight result is discarded, `rsp_valid`=0 on the next cycle, and `op_cnt` is cleared, not incremented.
- Reset dominates any simultaneous handshake.

## Timing
- Request handshake cycle T (IDLE): `alu_*` carries the payload from T+1 (EXEC).
- `rsp_valid` rises at T+2.
- With `rsp_ready` tied high: the response is accepted at the end of T+2 and the block is back in IDLE at T+3.
- Minimum period is 3 cycles per operation.
- No combinational path from `alu_out` to any output. The only combinational paths are `reqN_valid` → `reqN_ready`.
- Back-pressure: while `rsp_ready`=0 the block stays in RESP indefinitely, and both `reqN_ready` stay 0.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: strict priority. Requester 0 always wins when both are valid, and `prio` is not updated (remains 0).
- Undefined (default): round-robin as described in Operation.

## Test plan
- Single request: `req0_valid`=1, opcode=3'b000, a=4'd3, b=4'd5, ALU model returns `alu_out`=6'd8, overflow=0, zero=0, `rsp_ready`=1.
  - `req0_ready` pulses at T.
  - `alu_src_a`=3 and `alu_src_b`=5 at T+1.
  - `rsp_valid`=1, `rsp_id`=0, `rsp_data`=6'd8 at T+2.
  - `op_cnt`=1 at T+3.
- Contention: both valid continuously after reset, 4 operations.
  - Grants are 0, 1, 0, 1.
  - `rsp_id` sequence is 0, 1, 0, 1, and `op_cnt`=4.
  - With `ALU_ARB_FIXED_PRIO_EN`: all four grants go to 0.
- Back-pressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` rises.
  - `rsp_data`/`rsp_id` are unchanged throughout and both `reqN_ready`=0.
  - The response is accepted on the first cycle `rsp_ready`=1.
- Flag capture: ALU model returns `alu_out`=6'd0, zero=1, overflow=1.
  - Response shows `rsp_zero`=1, `rsp_overflow`=1, `rsp_data`=0.
- Reset mid-op: assert `reset` for 1 cycle while in RESP with `rsp_ready`=0.
  - The next cycle shows `rsp_valid`=0, `op_cnt`=0, all `alu_*`=0, state IDLE.
  - The next request is granted to requester 0.
- Counter wrap: with `CNT_W`=2, complete 5 operations.
  - `op_cnt` sequence is 1, 2, 3, 0, 1.
